pwm_ctrl: RTL
=============

# pwm_ctrl

Sequencing and configuration controller for the PWM datapath. Owns the PWM period counter and duty comparator, drives the shared prescaler tick generator (`final_value` / `enable` / `done` style interface), and accepts new period/duty/prescale settings over a valid/ready handshake. All settings are double-buffered and committed only at a period boundary. An optional duty ramp provides soft-start and soft-change.

## Interface
- `TIMER_BITS`, default 4: prescaler compare width; must match the tick generator.
- `R`, default 8: PWM counter and duty resolution in bits.
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: run request. Level-sensitive.
- `cfg_valid` in 1: configuration offer.
- `cfg_ready` out 1: configuration accept; high when no configuration is pending.
- `cfg_prescale` in TIMER_BITS: tick generator final value; tick every `cfg_prescale+1` clocks.
- `cfg_period` in R: PWM counter top; period is `cfg_period+1` ticks.
- `cfg_duty` in R: target duty, in ticks high per period.
- `cfg_step` in R: ramp step; 0 means apply duty immediately.
- `tick_final` out TIMER_BITS: to the tick generator's final value; equals active prescale.
- `tick_enable` out 1: to the tick generator's enable; high only in RUN.
- `tick_done` in 1: tick from the tick generator; ignored outside RUN.
- `pwm_out` out 1: PWM waveform.
- `period_start` out 1: one-cycle pulse when the counter enters 0 in RUN.
- `running` out 1: state == RUN.

## Operation
- **Registers**
  - Staging set: prescale, period, duty, step, plus a `pending` flag.
  - Active set: prescale, period, target duty, step.
  - Working registers: `cnt` (R bits) and `cur_duty` (R bits).
- **Reset values**
  - `pending` = 0.
  - Active prescale = 0, period = 2^R−1, target = 0, step = 0.
  - `cnt` = 0, `cur_duty` = 0, state = IDLE.
  - Outputs: `cfg_ready`=1, `tick_enable`=0, `tick_final`=0, `pwm_out`=0, `period_start`=0, `running`=0.
- **Handshake**
  - `cfg_ready` = !`pending`.
  - A transfer occurs when `cfg_valid` & `cfg_ready`; it loads staging and sets `pending`.
  - `cfg_valid` held while `cfg_ready` is low has no effect; no data is lost or overwritten.
- **Commit** (staging → active, clears `pending`) happens:
  - in IDLE, on the cycle after the transfer;
  - on RUN entry;
  - at each RUN period boundary.
- **Period boundary**: RUN & `tick_done` & `cnt` == active period.
- **State machine**
  - IDLE → RUN when `enable`=1. On entry: `cnt`=0, commit if pending, apply a duty update, pulse `period_start`.
  - RUN → IDLE when `enable`=0, one cycle later. On exit: `cnt`=0, `cur_duty`=0, `pwm_out` low, `tick_enable` low. A pending configuration is kept.
- **Counting (RUN)**
  - On `tick_done`: `cnt`+1.
  - At the boundary, `cnt` wraps to 0, then commit if pending, then apply a duty update.
- **Duty update**
  - Step = 0: `cur_duty` = target.
  - Otherwise `cur_duty` moves toward target by step and saturates at target. Compute in R+1 bits; never overshoot or wrap.
  - The update uses the newly committed target and step.
- **Output**
  - `pwm_out` = RUN & (`cnt` < `cur_duty`), decoded from registered state only.
  - `cur_duty` > period gives constant high; `cur_duty` = 0 gives constant low.
- **Tick generator phase**: not cleared by this block. The first RUN period may be short or long by up to 2^TIMER_BITS clocks. A new prescale takes effect from the boundary that commits it.

## Timing
- `enable` rise at edge N: `running`, `tick_enable` and `period_start` are high after edge N+1.
- `enable` fall: `pwm_out` and `tick_enable` are low after the next edge.
- Handshake → IDLE commit: 1 cycle. `cfg_ready` is low for exactly that cycle.
- Handshake in RUN: `cfg_ready` stays low until the cycle after the committing boundary.
- A transfer on the same cycle as a boundary (`pending` was 0) is committed at the following boundary, not the current one.
- `period_start` coincides with `cnt`=0 and with new active values visible.
- `reset_n` asserted mid-run: all registers and outputs return to reset values immediately, and the pending configuration is discarded.

## Test plan
- **Reset:** assert `reset_n`=0 mid-run → `pwm_out`, `tick_enable`, `running` are 0 and `cfg_ready`=1 asynchronously; `tick_final`=0.
- **Basic run:** config prescale=3, period=9, duty=4, step=0, then `enable` → from the second period, `period_start` every 40 clks and `pwm_out` high 16 of 40 clks.
- **Double-buffering:** write duty=7 mid-period → `cfg_ready` low; old duty persists to the boundary; after the next `period_start`, high time = 28 clks and `cfg_ready`=1.
- **Ramp:** target=8, step=3 from IDLE → successive periods have high ticks 3, 6, 8, 8. Then target=2 → 5, 2, 2.
- **Saturation:** duty=12, period=9 → `pwm_out` constant 1. Duty=0 → constant 0 with no glitch.
- **Disable mid-period:** `enable` dropped at `cnt`=5 → next cycle `pwm_out`=0 and `tick_enable`=0. Re-enable with step=3, target=8 → ramp restarts at 3.

Source files
------------

// File: rtl/pwm_ctrl.sv
// pwm_ctrl
// Sequencing and configuration controller for the PWM datapath. Owns the PWM
// period counter and duty comparator, drives the shared prescaler tick
// generator, and accepts double-buffered period/duty/prescale/step settings
// over a valid/ready handshake. Settings are committed only at a period
// boundary (or immediately while idle). A non-zero step ramps the working
// duty toward the target one step per period.
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   enable               run request (level)
//   cfg_valid/cfg_ready  configuration handshake; ready = nothing pending
//   cfg_prescale         tick generator final value (tick every N+1 clocks)
//   cfg_period           counter top, period = cfg_period+1 ticks
//   cfg_duty             target duty, ticks high per period
//   cfg_step             ramp step, 0 = apply duty immediately
//   tick_final           active prescale to the tick generator
//   tick_enable          tick generator enable, high only in RUN
//   tick_done            tick from the tick generator
//   pwm_out              PWM waveform
//   period_start         one-cycle pulse when the counter enters 0 in RUN
//   running              state == RUN
//
// state | meaning
// IDLE  | stopped; outputs low, a pending configuration commits next cycle
// RUN   | counting ticks, commits pending configuration at each boundary

module pwm_ctrl #(
   parameter int TIMER_BITS = 4,
   parameter int R          = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [TIMER_BITS-1:0] cfg_prescale,
   input  logic [R-1:0]          cfg_period,
   input  logic [R-1:0]          cfg_duty,
   input  logic [R-1:0]          cfg_step,
   output logic [TIMER_BITS-1:0] tick_final,
   output logic                  tick_enable,
   input  logic                  tick_done,
   output logic                  pwm_out,
   output logic                  period_start,
   output logic                  running
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t                state;
   logic                  pending;
   logic [TIMER_BITS-1:0] stg_prescale;
   logic [R-1:0]          stg_period;
   logic [R-1:0]          stg_duty;
   logic [R-1:0]          stg_step;
   logic [TIMER_BITS-1:0] act_prescale;
   logic [R-1:0]          act_period;
   logic [R-1:0]          act_target;
   logic [R-1:0]          act_step;
   logic [R-1:0]          cnt;
   logic [R-1:0]          cur_duty;

   logic                  xfer;
   logic                  boundary;
   logic                  commit;
   logic [R-1:0]          nxt_target;
   logic [R-1:0]          nxt_step;

   // One ramp step toward the target, saturating at the target. The
   // difference is formed in R+1 bits so neither direction can wrap.
   function automatic logic [R-1:0] duty_step(input logic [R-1:0] cur,
                                              input logic [R-1:0] tgt,
                                              input logic [R-1:0] stp);
      logic [R:0] tmp;
      tmp = '0;
      if (stp == '0) begin
         return tgt;
      end
      if (cur < tgt) begin
         tmp = {1'b0, cur} + {1'b0, stp};
         return (tmp >= {1'b0, tgt}) ? tgt : tmp[R-1:0];
      end
      if (cur > tgt) begin
         tmp = {1'b0, cur} - {1'b0, tgt};
         return (tmp <= {1'b0, stp}) ? tgt : (cur - stp);
      end
      return tgt;
   endfunction

   assign xfer     = cfg_valid && !pending;
   assign boundary = (state == RUN) && tick_done && (cnt == act_period);

   // Exit from RUN takes priority over a coincident boundary, so a pending
   // configuration survives a disable untouched.
   assign commit = pending &&
                   ((state == IDLE) || (enable && boundary));

   // Duty updates always see the values being committed on the same edge.
   always_comb begin
      nxt_target = act_target;
      nxt_step   = act_step;
      if (commit) begin
         nxt_target = stg_duty;
         nxt_step   = stg_step;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         pending      <= 1'b0;
         stg_prescale <= '0;
         stg_period   <= '0;
         stg_duty     <= '0;
         stg_step     <= '0;
         act_prescale <= '0;
         act_period   <= '1;
         act_target   <= '0;
         act_step     <= '0;
         cnt          <= '0;
         cur_duty     <= '0;
         period_start <= 1'b0;
      end else begin
         period_start <= 1'b0;

         if (xfer) begin
            stg_prescale <= cfg_prescale;
            stg_period   <= cfg_period;
            stg_duty     <= cfg_duty;
            stg_step     <= cfg_step;
            pending      <= 1'b1;
         end else if (commit) begin
            pending      <= 1'b0;
         end

         if (commit) begin
            act_prescale <= stg_prescale;
            act_period   <= stg_period;
            act_target   <= stg_duty;
            act_step     <= stg_step;
         end

         case (state)
            IDLE: begin
               if (enable) begin
                  state        <= RUN;
                  cnt          <= '0;
                  cur_duty     <= duty_step(cur_duty, nxt_target, nxt_step);
                  period_start <= 1'b1;
               end
            end
            RUN: begin
               if (!enable) begin
                  state    <= IDLE;
                  cnt      <= '0;
                  cur_duty <= '0;
               end else if (tick_done) begin
                  if (cnt == act_period) begin
                     cnt          <= '0;
                     cur_duty     <= duty_step(cur_duty, nxt_target, nxt_step);
                     period_start <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign cfg_ready   = !pending;
   assign tick_final  = act_prescale;
   assign running     = (state == RUN);
   assign tick_enable = (state == RUN);
   assign pwm_out     = (state == RUN) && (cnt < cur_duty);

endmodule
